// File: rtl/mult_repadd_param.sv
`default_nettype none
// ============================================================================
// Module  : mult_repadd_param
// Brief   : Signed/unsigned multiplier built from repeated addition, one add
//           per clock, with optional operand swap to minimise iterations.
// Revision: 1.0 - initial release
// ============================================================================
module mult_repadd_param #(
    parameter int WIDTH = 16,
    parameter bit SWAP  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam logic [WIDTH-1:0]   c_ONE  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE2 = (2*WIDTH)'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH-1:0]     w_cnt_ld, w_m_ld;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly
    // the magnitude we want when read as unsigned.
    assign w_abs_a = (sgn && a[WIDTH-1]) ? (~a + c_ONE) : a;
    assign w_abs_b = (sgn && b[WIDTH-1]) ? (~b + c_ONE) : b;

    generate
        if (SWAP) begin : g_swap
            // Ties fall to the b side for the iteration count.
            assign w_cnt_ld = (w_abs_b <= w_abs_a) ? w_abs_b : w_abs_a;
            assign w_m_ld   = (w_abs_b <= w_abs_a) ? w_abs_a : w_abs_b;
        end else begin : g_noswap
            assign w_cnt_ld = w_abs_b;
            assign w_m_ld   = w_abs_a;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = w_m_ld;
                    cnt_d   = w_cnt_ld;
                    p_d     = '0;
                    neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    p_d   = p_q + {{WIDTH{1'b0}}, m_q};
                    cnt_d = cnt_q - c_ONE;
                end else begin
                    // Two's complement of zero is zero, so no negative zero.
                    result_d = neg_q ? (~p_q + c_ONE2) : p_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_repadd_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_repadd_param
// Brief   : Directed, table-driven bench for mult_repadd_param.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult_repadd_param;

    localparam int c_LIMIT = 70000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s1_start = 1'b0, s1_sgn = 1'b0;
    logic [15:0] s1_a = '0, s1_b = '0;
    logic        busy1, done1;
    logic [31:0] res1;

    logic        s0_start = 1'b0, s0_sgn = 1'b0;
    logic [15:0] s0_a = '0, s0_b = '0;
    logic        busy0, done0;
    logic [31:0] res0;

    logic        s4_start = 1'b0, s4_sgn = 1'b0;
    logic [3:0]  s4_a = '0, s4_b = '0;
    logic        busy4, done4;
    logic [7:0]  res4;

    mult_repadd_param #(.WIDTH(16), .SWAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .sgn(s1_sgn), .a(s1_a), .b(s1_b),
        .busy(busy1), .done(done1), .result(res1));

    mult_repadd_param #(.WIDTH(16), .SWAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(s0_start), .sgn(s0_sgn), .a(s0_a), .b(s0_b),
        .busy(busy0), .done(done0), .result(res0));

    mult_repadd_param #(.WIDTH(4), .SWAP(1'b1)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .sgn(s4_sgn), .a(s4_a), .b(s4_b),
        .busy(busy4), .done(done4), .result(res4));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start1(input logic sg, input logic [15:0] aa, input logic [15:0] bb);
        s1_sgn = sg; s1_a = aa; s1_b = bb; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
    endtask

    task automatic wait1(output int lat);
        lat = 0;
        while (!done1 && lat < c_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op1(input string nm, input logic sg, input logic [15:0] aa,
                       input logic [15:0] bb, input logic [31:0] er, input int el);
        int lat;
        start1(sg, aa, bb);
        chk({nm, "_busy"}, longint'(busy1), 1);
        wait1(lat);
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_res"}, longint'(res1), longint'(er));
        @(posedge clk); #1;
        chk({nm, "_donepulse"}, longint'(done1), 0);
    endtask

    task automatic op4(input string nm, input logic sg, input logic [3:0] aa,
                       input logic [3:0] bb, input logic [7:0] er, input int el);
        int lat;
        s4_sgn = sg; s4_a = aa; s4_b = bb; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        lat = 0;
        while (!done4 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_res"}, longint'(res4), longint'(er));
    endtask

    vec_t vecs[$];

    initial begin
        int  lat;
        bit  seen;
        vecs = '{
            '{"u24x4",     1'b0, 16'd24,   16'd4,    32'd96,        5},
            '{"u4x24",     1'b0, 16'd4,    16'd24,   32'd96,        5},
            '{"u0x1234",   1'b0, 16'd0,    16'd1234, 32'd0,         1},
            '{"u1234x0",   1'b0, 16'd1234, 16'd0,    32'd0,         1},
            '{"sm5x0",     1'b1, 16'hFFFB, 16'd0,    32'd0,         1},
            '{"sm3x7",     1'b1, 16'hFFFD, 16'd7,    32'hFFFFFFEB,  4},
            '{"s7xm3",     1'b1, 16'd7,    16'hFFFD, 32'hFFFFFFEB,  4},
            '{"smaxnegsq", 1'b1, 16'h8000, 16'h8000, 32'h40000000,  32769},
            '{"smaxnegx1", 1'b1, 16'h8000, 16'd1,    32'hFFFF8000,  2},
            '{"u100x3",    1'b0, 16'd100,  16'd3,    32'd300,       4},
            '{"u8000x2",   1'b0, 16'h8000, 16'd2,    32'h00010000,  3},
            '{"sm1xm1",    1'b1, 16'hFFFF, 16'hFFFF, 32'd1,         2}
        };

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy1", longint'(busy1), 0);
        chk("rst_done1", longint'(done1), 0);
        chk("rst_res1",  longint'(res1),  0);
        chk("rst_res0",  longint'(res0),  0);
        chk("rst_res4",  longint'(res4),  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SWAP=0 iterates on b, so 4*24 needs 24 adds.
        s0_sgn = 1'b0; s0_a = 16'd4; s0_b = 16'd24; s0_start = 1'b1;
        @(posedge clk); #1;
        s0_start = 1'b0;
        lat = 0;
        while (!done0 && lat < c_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ns_4x24_lat", lat, 25);
        chk("ns_4x24_res", longint'(res0), 96);

        fork
            begin : long_run
                int  l0;
                bit  busy_bad;
                s0_sgn = 1'b0; s0_a = 16'hFFFF; s0_b = 16'hFFFF; s0_start = 1'b1;
                @(posedge clk); #1;
                s0_start = 1'b0;
                l0 = 0; busy_bad = 1'b0;
                while (!done0 && l0 < c_LIMIT) begin
                    if (!busy0) busy_bad = 1'b1;
                    @(posedge clk); #1;
                    l0++;
                end
                chk("ns_ffff_lat",  l0, 65536);
                chk("ns_ffff_res",  longint'(res0), 64'hFFFE0001);
                chk("ns_ffff_busy", longint'(busy_bad), 0);
            end
            begin : table_run
                for (int i = 0; i < vecs.size(); i++)
                    op1(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                        vecs[i].exp_res, vecs[i].exp_lat);
                op4("w4_15x15", 1'b0, 4'hF, 4'hF, 8'hE1, 16);
                op4("w4_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40, 9);
                op4("w4_m1x3",  1'b1, 4'hF, 4'h3, 8'hFD, 2);
            end
        join

        // Start while busy must be dropped: 10*20 still takes 11 edges.
        start1(1'b0, 16'd10, 16'd20);
        repeat (3) @(posedge clk);
        #1;
        s1_a = 16'd9; s1_b = 16'd9; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        wait1(lat);
        chk("ignore_lat", lat + 4, 11);
        chk("ignore_res", longint'(res1), 200);
        @(posedge clk); #1;

        // Back-to-back: second start issued in the done cycle.
        start1(1'b0, 16'd5, 16'd6);
        wait1(lat);
        chk("b2b_first_lat", lat, 6);
        chk("b2b_first_res", longint'(res1), 30);
        op1("b2b_second", 1'b0, 16'd7, 16'd3, 32'd21, 4);

        // Reset mid-run aborts silently.
        start1(1'b0, 16'd50, 16'd60);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", longint'(busy1), 0);
        chk("abort_done", longint'(done1), 0);
        chk("abort_res",  longint'(res1),  0);
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done1 || busy1) seen = 1'b1;
        end
        chk("abort_quiet", longint'(seen), 0);
        op1("after_abort", 1'b0, 16'd3, 16'd3, 32'd9, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
